dmi_request_sequencer: RTL and testbench

Converts DMI requests from the JTAG TAP (dmi register, IR 0x11) into single start/done transactions for the wishbone master that talks to the RISC-V DM slave. Sits between `jtag_tap` and `wishbone_master`. Tracks one outstanding access, detects late arrivals, times out hung accesses and keeps the sticky DMI status the TAP returns on the next capture. Inputs are already in the `clk_i` domain.

---
 rtl/dmi_pkg.sv | 28 ++
 rtl/dmi_request_sequencer.sv | 152 +++++++++++++++
 tb/tb_dmi_request_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_pkg.sv
// Shared DMI definitions: op codes, sticky status codes, sequencer states and
// the debug-module register addresses used by the DMI request path.
package dmi_pkg;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2,
    DMI_OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_ST_OK     = 2'd0,
    DMI_ST_FAILED = 2'd2,
    DMI_ST_BUSY   = 2'd3
  } dmi_status_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_e;

  localparam logic [6:0] DMI_ADDR_DATA0     = 7'h04;
  localparam logic [6:0] DMI_ADDR_DMCONTROL = 7'h10;
  localparam logic [6:0] DMI_ADDR_DMSTATUS  = 7'h11;

endpackage

// File: rtl/dmi_request_sequencer.sv
// Turns TAP dmi Update-DR requests into single start/done wishbone transactions,
// with one outstanding access, a hang timeout and the sticky DMI status.
module dmi_request_sequencer
  import dmi_pkg::*;
#(
  parameter int ABITS          = 7,
  parameter int DATA_W         = 32,
  parameter int WB_DATA_W      = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dmi_req_valid_i,
  input  logic [1:0]           dmi_req_op_i,
  input  logic [ABITS-1:0]     dmi_req_addr_i,
  input  logic [DATA_W-1:0]    dmi_req_data_i,
  input  logic                 dmireset_i,
  input  logic                 dmihardreset_i,
  output logic [DATA_W-1:0]    dmi_rsp_data_o,
  output logic [1:0]           dmi_rsp_op_o,
  output logic                 busy_o,
  output logic                 start_read_transaction_o,
  output logic                 start_write_transaction_o,
  output logic [31:0]          addr_o,
  output logic [WB_DATA_W-1:0] write_transaction_data_o,
  input  logic                 done_i,
  input  logic [WB_DATA_W-1:0] read_data_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e            state_q;
  dmi_status_e           status_q, status_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  is_read_q;
  logic [DATA_W-1:0]     rsp_data_q;
  logic                  busy_q;
  logic                  start_rd_q, start_wr_q;
  logic [31:0]           addr_q;
  logic [WB_DATA_W-1:0]  wdata_q;

  logic                  req_rw;
  logic                  req_is_read;
  logic                  accept;
  logic                  timeout;
  logic [31:0]           addr_ext;
  logic [WB_DATA_W-1:0]  wdata_ext;
  logic                  unused_rd;

  assign unused_rd = ^read_data_i;

  always_comb begin
    req_is_read = (dmi_req_op_i == DMI_OP_READ);
    req_rw      = dmi_req_valid_i &&
                  ((dmi_req_op_i == DMI_OP_READ) || (dmi_req_op_i == DMI_OP_WRITE));
    accept      = !dmihardreset_i && req_rw && (state_q == ST_IDLE) &&
                  (status_q == DMI_ST_OK);
    timeout     = (state_q == ST_WAIT) && !done_i && (cnt_q == CNT_MAX);

    addr_ext                  = '0;
    addr_ext[ABITS-1:0]       = dmi_req_addr_i;
    wdata_ext                 = '0;
    wdata_ext[DATA_W-1:0]     = dmi_req_data_i;
  end

  // Sticky status: clears first, then failure (never over busy), then busy wins,
  // so a dmireset coinciding with a busy-causing request still leaves BUSY.
  always_comb begin
    status_d = status_q;
    if (dmihardreset_i) begin
      status_d = DMI_ST_OK;
    end else begin
      if (dmireset_i) begin
        status_d = DMI_ST_OK;
      end else if (timeout && (status_q != DMI_ST_BUSY)) begin
        status_d = DMI_ST_FAILED;
      end
      if (req_rw && (state_q != ST_IDLE)) begin
        status_d = DMI_ST_BUSY;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      status_q   <= DMI_ST_OK;
      cnt_q      <= '0;
      is_read_q  <= 1'b0;
      rsp_data_q <= '0;
      busy_q     <= 1'b0;
      start_rd_q <= 1'b0;
      start_wr_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      status_q   <= status_d;
      start_rd_q <= 1'b0;
      start_wr_q <= 1'b0;
      if (dmihardreset_i) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              addr_q     <= addr_ext;
              wdata_q    <= wdata_ext;
              is_read_q  <= req_is_read;
              start_rd_q <= req_is_read;
              start_wr_q <= !req_is_read;
              busy_q     <= 1'b1;
              state_q    <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            cnt_q   <= '0;
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (done_i) begin
              if (is_read_q) begin
                rsp_data_q <= read_data_i[DATA_W-1:0];
              end
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else if (cnt_q == CNT_MAX) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign dmi_rsp_data_o            = rsp_data_q;
  assign dmi_rsp_op_o              = status_q;
  assign busy_o                    = busy_q;
  assign start_read_transaction_o  = start_rd_q;
  assign start_write_transaction_o = start_wr_q;
  assign addr_o                    = addr_q;
  assign write_transaction_data_o  = wdata_q;

endmodule

// File: tb/tb_dmi_request_sequencer.sv
// Directed bench for dmi_request_sequencer: a per-cycle vector table followed by
// hand-written timeout, hardreset and asynchronous reset sequences.
module tb_dmi_request_sequencer;

  localparam int ABITS     = 7;
  localparam int DATA_W    = 32;
  localparam int WB_DATA_W = 64;
  localparam int TMO       = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 dmi_req_valid;
  logic [1:0]           dmi_req_op;
  logic [ABITS-1:0]     dmi_req_addr;
  logic [DATA_W-1:0]    dmi_req_data;
  logic                 dmireset;
  logic                 dmihardreset;
  logic [DATA_W-1:0]    dmi_rsp_data;
  logic [1:0]           dmi_rsp_op;
  logic                 busy;
  logic                 start_rd;
  logic                 start_wr;
  logic [31:0]          addr;
  logic [WB_DATA_W-1:0] wdata;
  logic                 done;
  logic [WB_DATA_W-1:0] read_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmi_request_sequencer #(
    .ABITS(ABITS), .DATA_W(DATA_W), .WB_DATA_W(WB_DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .dmi_req_valid_i(dmi_req_valid), .dmi_req_op_i(dmi_req_op),
    .dmi_req_addr_i(dmi_req_addr), .dmi_req_data_i(dmi_req_data),
    .dmireset_i(dmireset), .dmihardreset_i(dmihardreset),
    .dmi_rsp_data_o(dmi_rsp_data), .dmi_rsp_op_o(dmi_rsp_op), .busy_o(busy),
    .start_read_transaction_o(start_rd), .start_write_transaction_o(start_wr),
    .addr_o(addr), .write_transaction_data_o(wdata),
    .done_i(done), .read_data_i(read_data)
  );

  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [6:0]  a;
    logic [31:0] d;
    logic        dr;
    logic        hr;
    logic        dn;
    logic [63:0] rd;
    logic        e_busy;
    logic        e_srd;
    logic        e_swr;
    logic [1:0]  e_st;
    logic [31:0] e_rsp;
    logic [31:0] e_addr;
    logic [63:0] e_wd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [1:0] op, logic [6:0] a, logic [31:0] d,
                              logic dr, logic dn, logic [63:0] rd,
                              logic eb, logic esr, logic esw, logic [1:0] est,
                              logic [31:0] ersp, logic [31:0] ea, logic [63:0] ewd);
    vec_t r;
    r.v = v; r.op = op; r.a = a; r.d = d; r.dr = dr; r.hr = 1'b0; r.dn = dn; r.rd = rd;
    r.e_busy = eb; r.e_srd = esr; r.e_swr = esw; r.e_st = est;
    r.e_rsp = ersp; r.e_addr = ea; r.e_wd = ewd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [6:0] a,
                       input logic [31:0] d, input logic dr, input logic hr,
                       input logic dn, input logic [63:0] rd);
    dmi_req_valid = v; dmi_req_op = op; dmi_req_addr = a; dmi_req_data = d;
    dmireset = dr; dmihardreset = hr; done = dn; read_data = rd;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 7'h0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic eb, input logic esr, input logic esw,
                         input logic [1:0] est, input logic [31:0] ersp,
                         input logic [31:0] ea, input logic [63:0] ewd);
    chk({tag, " busy"},  64'(busy),         64'(eb));
    chk({tag, " srd"},   64'(start_rd),     64'(esr));
    chk({tag, " swr"},   64'(start_wr),     64'(esw));
    chk({tag, " st"},    64'(dmi_rsp_op),   64'(est));
    chk({tag, " rsp"},   64'(dmi_rsp_data), 64'(ersp));
    chk({tag, " addr"},  64'(addr),         64'(ea));
    chk({tag, " wdata"}, wdata,             ewd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 64'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // args: v op addr data dmireset done rdata | busy srd swr st rsp addr wdata
    tbl.push_back(mk(0,0,7'h00,32'h0,0,0,64'h0,                  0,0,0,0,32'h0,32'h0,64'h0));
    tbl.push_back(mk(1,1,7'h11,32'h0,0,0,64'h0,                  1,1,0,0,32'h0,32'h11,64'h0));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,0,64'h0,                  1,0,0,0,32'h0,32'h11,64'h0));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,0,64'h0,                  1,0,0,0,32'h0,32'h11,64'h0));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,0,64'h0,                  1,0,0,0,32'h0,32'h11,64'h0));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,1,64'hDEADBEEF_00400382,  0,0,0,0,32'h00400382,32'h11,64'h0));
    tbl.push_back(mk(1,2,7'h10,32'h80000001,0,0,64'h0,           1,0,1,0,32'h00400382,32'h10,64'h80000001));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,0,64'h0,                  1,0,0,0,32'h00400382,32'h10,64'h80000001));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,1,64'h11112222_33334444,  0,0,0,0,32'h00400382,32'h10,64'h80000001));
    tbl.push_back(mk(1,1,7'h04,32'h0,0,0,64'h0,                  1,1,0,0,32'h00400382,32'h04,64'h0));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,0,64'h0,                  1,0,0,0,32'h00400382,32'h04,64'h0));
    tbl.push_back(mk(1,1,7'h11,32'h0,0,0,64'h0,                  1,0,0,3,32'h00400382,32'h04,64'h0));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,1,64'h00000000_CAFEF00D,  0,0,0,3,32'hCAFEF00D,32'h04,64'h0));
    tbl.push_back(mk(1,1,7'h11,32'h0,0,0,64'h0,                  0,0,0,3,32'hCAFEF00D,32'h04,64'h0));
    tbl.push_back(mk(1,0,7'h11,32'h0,0,0,64'h0,                  0,0,0,3,32'hCAFEF00D,32'h04,64'h0));
    tbl.push_back(mk(0,0,7'h00,32'h0,1,0,64'h0,                  0,0,0,0,32'hCAFEF00D,32'h04,64'h0));
    tbl.push_back(mk(1,1,7'h11,32'h0,0,0,64'h0,                  1,1,0,0,32'hCAFEF00D,32'h11,64'h0));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,0,64'h0,                  1,0,0,0,32'hCAFEF00D,32'h11,64'h0));
    tbl.push_back(mk(1,3,7'h11,32'h0,0,0,64'h0,                  1,0,0,0,32'hCAFEF00D,32'h11,64'h0));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,1,64'h00000000_12345678,  0,0,0,0,32'h12345678,32'h11,64'h0));
    tbl.push_back(mk(1,3,7'h10,32'hFF,0,0,64'h0,                 0,0,0,0,32'h12345678,32'h11,64'h0));
    tbl.push_back(mk(1,0,7'h10,32'hFF,0,0,64'h0,                 0,0,0,0,32'h12345678,32'h11,64'h0));
    tbl.push_back(mk(1,2,7'h10,32'h5,0,0,64'h0,                  1,0,1,0,32'h12345678,32'h10,64'h5));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,0,64'h0,                  1,0,0,0,32'h12345678,32'h10,64'h5));
    tbl.push_back(mk(1,1,7'h11,32'h0,1,0,64'h0,                  1,0,0,3,32'h12345678,32'h10,64'h5));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,1,64'h00000000_FFFFFFFF,  0,0,0,3,32'h12345678,32'h10,64'h5));
    tbl.push_back(mk(0,0,7'h00,32'h0,1,0,64'h0,                  0,0,0,0,32'h12345678,32'h10,64'h5));
    tbl.push_back(mk(1,1,7'h11,32'h0,0,0,64'h0,                  1,1,0,0,32'h12345678,32'h11,64'h0));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,0,64'h0,                  1,0,0,0,32'h12345678,32'h11,64'h0));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,1,64'h00000000_A5A5A5A5,  0,0,0,0,32'hA5A5A5A5,32'h11,64'h0));
    tbl.push_back(mk(1,2,7'h04,32'h77,0,0,64'h0,                 1,0,1,0,32'hA5A5A5A5,32'h04,64'h77));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,0,64'h0,                  1,0,0,0,32'hA5A5A5A5,32'h04,64'h77));
    tbl.push_back(mk(0,0,7'h00,32'h0,0,1,64'h0,                  0,0,0,0,32'hA5A5A5A5,32'h04,64'h77));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].dr, tbl[i].hr, tbl[i].dn, tbl[i].rd);
      tick();
      chk_all($sformatf("row%0d", i), tbl[i].e_busy, tbl[i].e_srd, tbl[i].e_swr,
              tbl[i].e_st, tbl[i].e_rsp, tbl[i].e_addr, tbl[i].e_wd);
    end

    // Timeout: no done_i, FAILED and idle exactly TMO cycles after WAIT entry
    drive(1'b1, 2'd1, 7'h11, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    chk("tmo start", 64'(start_rd), 64'd1);
    idle();
    tick();
    for (int k = 0; k < TMO - 1; k++) tick();
    chk("tmo busy before limit", 64'(busy), 64'd1);
    chk("tmo st before limit", 64'(dmi_rsp_op), 64'd0);
    tick();
    chk("tmo busy at limit", 64'(busy), 64'd0);
    chk("tmo st at limit", 64'(dmi_rsp_op), 64'd2);
    drive(1'b0, 2'd0, 7'h0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h0BADF00D);
    tick();
    idle();
    chk("late done rsp", 64'(dmi_rsp_data), 64'hA5A5A5A5);
    chk("late done st", 64'(dmi_rsp_op), 64'd2);
    drive(1'b1, 2'd1, 7'h11, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    chk("failed drop srd", 64'(start_rd), 64'd0);
    chk("failed drop busy", 64'(busy), 64'd0);
    drive(1'b0, 2'd0, 7'h0, 32'h0, 1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    chk("dmireset clears failed", 64'(dmi_rsp_op), 64'd0);

    // Hardreset in WAIT with busy status pending
    drive(1'b1, 2'd1, 7'h04, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    idle();
    tick();
    drive(1'b1, 2'd2, 7'h10, 32'h1, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    chk("hr pre st", 64'(dmi_rsp_op), 64'd3);
    drive(1'b0, 2'd0, 7'h0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    tick();
    chk("hr busy", 64'(busy), 64'd0);
    chk("hr st", 64'(dmi_rsp_op), 64'd0);
    chk("hr rsp held", 64'(dmi_rsp_data), 64'hA5A5A5A5);
    drive(1'b0, 2'd0, 7'h0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h00000BAD);
    tick();
    chk("hr stray done rsp", 64'(dmi_rsp_data), 64'hA5A5A5A5);
    drive(1'b1, 2'd1, 7'h10, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    chk("hr next srd", 64'(start_rd), 64'd1);
    chk("hr next addr", 64'(addr), 64'h10);
    idle();
    tick();
    drive(1'b0, 2'd0, 7'h0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h0000600D);
    tick();
    idle();
    chk("hr next rsp", 64'(dmi_rsp_data), 64'h600D);
    chk("hr next busy", 64'(busy), 64'd0);

    // Asynchronous reset in WAIT, checked before the next clock edge
    drive(1'b1, 2'd2, 7'h10, 32'h99, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    chk("ar swr", 64'(start_wr), 64'd1);
    idle();
    tick();
    chk("ar in wait", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async rst", 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 64'h0);
    #2;
    rst = 1'b0;
    tick();
    chk("post rst busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
